// File: rtl/simon_pkg.sv
// Shared constants, channel state encoding and priority helper for the tone arbiter.
package simon_pkg;
  localparam int N_REQ = 4;
  localparam int N_CH  = 2;

  localparam logic [3:0] SOUND_1 = 4'b0000;
  localparam logic [3:0] SOUND_2 = 4'b0001;
  localparam logic [3:0] SOUND_3 = 4'b0010;
  localparam logic [3:0] SOUND_4 = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    OWNED = 2'd2
  } ch_state_t;

  // Index of the lowest set bit (bit 0 is highest priority); 0 when v is empty.
  function automatic logic [1:0] first_idx(input logic [N_REQ-1:0] v);
    first_idx = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) first_idx = 2'(i);
    end
  endfunction
endpackage

// File: rtl/arb_channel.sv
// One tone channel: state, owner, minimum-hold counter and registered sound code.
// alloc loads a new owner from IDLE, or replaces the owner while OWNED (preemption).
module arb_channel
  import simon_pkg::*;
#(
  parameter int MIN_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_tone,
  input  logic                 alloc,
  input  logic [1:0]           alloc_idx,
  output ch_state_t            state,
  output logic [N_REQ-1:0]     grant,
  output logic                 on,
  output logic [3:0]           sound
);
  localparam logic [7:0] HOLD_LOAD = 8'(MIN_HOLD - 1);

  logic [1:0] owner;
  logic [7:0] cnt;
  logic       owner_req;

  assign owner_req = req[owner];
  assign on        = (state != IDLE);
  assign grant     = on ? (N_REQ'(1) << owner) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 2'd0;
      cnt   <= 8'd0;
      sound <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (alloc) begin
            state <= HOLD;
            owner <= alloc_idx;
            cnt   <= HOLD_LOAD;
            sound <= req_tone[{alloc_idx, 2'b00} +: 4];
          end else begin
            sound <= 4'd0;
          end
        end
        HOLD: begin
          if (!owner_req) begin
            state <= IDLE;
            cnt   <= 8'd0;
            sound <= 4'd0;
          end else begin
            sound <= req_tone[{owner, 2'b00} +: 4];
            // OWNED is entered on the edge where the counter reaches zero.
            if (cnt <= 8'd1) begin
              state <= OWNED;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        OWNED: begin
          if (!owner_req) begin
            state <= IDLE;
            sound <= 4'd0;
          end else if (alloc) begin
            state <= HOLD;
            owner <= alloc_idx;
            cnt   <= HOLD_LOAD;
            sound <= req_tone[{alloc_idx, 2'b00} +: 4];
          end else begin
            sound <= req_tone[{owner, 2'b00} +: 4];
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          sound <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: rtl/tone_arbiter.sv
// Two-channel priority tone arbiter; requester 0 wins, grants register one edge after request.
// Optional owner preemption after MIN_HOLD cycles is enabled by TONE_ARB_PREEMPT_EN.
module tone_arbiter
  import simon_pkg::*;
#(
  parameter int MIN_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] req_tone,
  output logic [3:0]  grant,
  output logic        ch1_on,
  output logic        ch2_on,
  output logic [3:0]  ch1_sound,
  output logic [3:0]  ch2_sound
);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  ch_state_t        st1, st2;
  logic [N_REQ-1:0] g1, g2;
  logic [N_REQ-1:0] pend, pend_b, rem;
  logic [1:0]       p1, p2, idx1, idx2;
  logic             alloc1, alloc2;
`ifdef TONE_ARB_PREEMPT_EN
  logic [1:0]       own1, own2, pr;
  logic             q1, q2;
`endif

  assign grant = g1 | g2;

  always_comb begin
    pend   = req & ~grant;
    p1     = first_idx(pend);
    alloc1 = (st1 == IDLE) && (|pend);
    idx1   = p1;
    pend_b = alloc1 ? (pend & ~(ONE << p1)) : pend;
    p2     = first_idx(pend_b);
    alloc2 = (st2 == IDLE) && (|pend_b);
    idx2   = p2;
    rem    = alloc2 ? (pend_b & ~(ONE << p2)) : pend_b;
`ifdef TONE_ARB_PREEMPT_EN
    // Only requesters left over after idle allocation may preempt; the weaker owner loses.
    own1 = first_idx(g1);
    own2 = first_idx(g2);
    pr   = first_idx(rem);
    q1   = (st1 == OWNED) && req[own1] && (|rem) && (pr < own1);
    q2   = (st2 == OWNED) && req[own2] && (|rem) && (pr < own2);
    if (q2 && (!q1 || (own2 > own1))) begin
      alloc2 = 1'b1;
      idx2   = pr;
    end else if (q1) begin
      alloc1 = 1'b1;
      idx1   = pr;
    end
`endif
  end

  arb_channel #(.MIN_HOLD(MIN_HOLD)) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_tone  (req_tone),
    .alloc     (alloc1),
    .alloc_idx (idx1),
    .state     (st1),
    .grant     (g1),
    .on        (ch1_on),
    .sound     (ch1_sound)
  );

  arb_channel #(.MIN_HOLD(MIN_HOLD)) u_ch2 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_tone  (req_tone),
    .alloc     (alloc2),
    .alloc_idx (idx2),
    .state     (st2),
    .grant     (g2),
    .on        (ch2_on),
    .sound     (ch2_sound)
  );
endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: directed scenarios plus random request traffic against a channel-level model.
module tb_tone_arbiter;
  import simon_pkg::*;

  localparam int MH = 16;
`ifdef TONE_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_tone;
  logic [3:0]  grant;
  logic        ch1_on, ch2_on;
  logic [3:0]  ch1_sound, ch2_sound;

  always #5 clk = ~clk;

  tone_arbiter #(.MIN_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_tone  (req_tone),
    .grant     (grant),
    .ch1_on    (ch1_on),
    .ch2_on    (ch2_on),
    .ch1_sound (ch1_sound),
    .ch2_sound (ch2_sound)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: per channel, who owns it and how many edges have passed since it was granted.
  bit         m_busy[2];
  int         m_own[2];
  int         m_age[2];
  logic [3:0] m_snd[2];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_busy[c] = 1'b0;
      m_own[c]  = 0;
      m_age[c]  = 0;
      m_snd[c]  = 4'd0;
    end
  endtask

  task automatic model_edge();
    bit was_busy[2];
    bit rel[2];
    bit fresh[2];
    int pend[$];
    int best;
    for (int c = 0; c < 2; c++) begin
      was_busy[c] = m_busy[c];
      rel[c]      = 1'b0;
      fresh[c]    = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (req[i] && !(m_busy[0] && m_own[0] == i) && !(m_busy[1] && m_own[1] == i))
        pend.push_back(i);
    end
    for (int c = 0; c < 2; c++) begin
      if (m_busy[c] && !req[m_own[c]]) begin
        rel[c]    = 1'b1;
        m_busy[c] = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!was_busy[c] && pend.size() > 0) begin
        m_own[c]  = pend.pop_front();
        m_busy[c] = 1'b1;
        fresh[c]  = 1'b1;
      end
    end
    if (PRE && pend.size() > 0) begin
      best = -1;
      for (int c = 0; c < 2; c++) begin
        if (was_busy[c] && !rel[c] && m_age[c] >= MH - 1 && m_own[c] > pend[0])
          if (best < 0 || m_own[c] > m_own[best]) best = c;
      end
      if (best >= 0) begin
        m_own[best] = pend[0];
        fresh[best] = 1'b1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (m_busy[c]) begin
        m_age[c] = fresh[c] ? 0 : m_age[c] + 1;
        m_snd[c] = req_tone[4*m_own[c] +: 4];
      end else begin
        m_age[c] = 0;
        m_snd[c] = 4'd0;
      end
    end
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = 4'd0;
    for (int c = 0; c < 2; c++) if (m_busy[c]) g[m_own[c]] = 1'b1;
    return g;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".grant"}, 16'(grant), 16'(model_grant()));
    chk({tag, ".ch1_on"}, 16'(ch1_on), 16'(m_busy[0]));
    chk({tag, ".ch2_on"}, 16'(ch2_on), 16'(m_busy[1]));
    chk({tag, ".ch1_sound"}, 16'(ch1_sound), 16'(m_snd[0]));
    chk({tag, ".ch2_sound"}, 16'(ch2_sound), 16'(m_snd[1]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".grant"}, 16'(grant), 16'h0);
    chk({tag, ".on"}, 16'({ch1_on, ch2_on}), 16'h0);
    chk({tag, ".sound"}, 16'({ch1_sound, ch2_sound}), 16'h0);
  endtask

  logic [3:0] flip;

  initial begin
    reset    = 1'b0;
    req      = 4'd0;
    req_tone = 16'd0;
    model_reset();
    #12;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single requester takes ch1 only.
    req      = 4'b0001;
    req_tone = {4'h7, 4'h5, 4'h3, SOUND_3};
    cycle("single");
    chk("single.grant_dir", 16'(grant), 16'h0001);
    chk("single.ch1_sound_dir", 16'(ch1_sound), 16'(SOUND_3));
    chk("single.ch2_on_dir", 16'(ch2_on), 16'h0);
    req = 4'b0000;
    cycle("release");
    cycle("idle");

    // Two requesters on the same edge, held well past MIN_HOLD, then req0 rises.
    req      = 4'b1010;
    req_tone = {SOUND_4, 4'h9, SOUND_2, 4'h1};
    cycle("pair");
    chk("pair.grant_dir", 16'(grant), 16'h000a);
    for (int i = 0; i < MH + 4; i++) begin
      req_tone[7:4] = 4'(i);
      cycle("pair_hold");
    end
    req = 4'b1011;
    cycle("late_req0");
    chk("late_req0.grant_dir", 16'(grant), PRE ? 16'h0003 : 16'h000a);
    cycle("late_req0b");

    // Owner drops while another requester waits: one silent cycle, then reallocation.
    req = 4'b1110;
    cycle("wait2");
    req = 4'b1100;
    cycle("drop1");
    cycle("regrant");
    cycle("regrant2");

    // Early competitor while the owner is still within its hold window.
    req = 4'b0000;
    cycle("clear");
    cycle("clear2");
    req = 4'b1010;
    cycle("hold_pair");
    repeat (4) cycle("hold_wait");
    req = 4'b1011;
    repeat (MH) cycle("hold_window");

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
      req = req ^ flip;
      for (int t = 0; t < 4; t++)
        if ($urandom_range(0, 3) == 0) req_tone[4*t +: 4] = 4'($urandom);
      if (n == 700) begin
        req = 4'b0110;
        cycle("pre_rst");
        #2 reset = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cycle("after_rst");
        chk("after_rst.grant_dir", 16'(grant), 16'h0006);
      end else begin
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
